modbus_tx_sequencer: RTL and testbench

Builds and sends the Modbus RTU response frame after the function handler finishes a request. On handler_done it latches the handler results, reads payload words from the response DPRAM, and appends the CRC-16. It streams bytes to the UART transmitter over a valid/ready handshake, then enforces the inter-frame gap. It sits between func_hander (dpram write side, result regs) and the UART tx byte engine.

---
 rtl/modbus_tx_sequencer_if.sv | 36 +++
 rtl/modbus_tx_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 tb/tb_modbus_tx_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// modbus_tx_sequencer_if
//
// Bundles the two buses the response sequencer talks over:
//   * UART byte channel: tx_data/tx_valid (sequencer -> UART),
//     tx_ready/tx_idle (UART -> sequencer)
//   * Response DPRAM read port: dpram_ren/dpram_raddr (sequencer -> RAM),
//     dpram_rdata (RAM -> sequencer, valid one cycle after dpram_ren)
//
// Handshake: a byte moves when tx_valid && tx_ready at a rising clk_in.
// While tx_valid is high and tx_ready is low, tx_data is held constant and
// tx_valid is not withdrawn (except by reset).
//
// Modports:
//   master - the sequencer
//   slave  - the UART transmitter / DPRAM side
// -----------------------------------------------------------------------------
interface modbus_tx_sequencer_if;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_idle;
    logic        dpram_ren;
    logic [7:0]  dpram_raddr;
    logic [15:0] dpram_rdata;

    modport master (
        output tx_data, tx_valid, dpram_ren, dpram_raddr,
        input  tx_ready, tx_idle, dpram_rdata
    );

    modport slave (
        input  tx_data, tx_valid, dpram_ren, dpram_raddr,
        output tx_ready, tx_idle, dpram_rdata
    );
endinterface

// File: rtl/modbus_tx_sequencer.sv
// -----------------------------------------------------------------------------
// modbus_tx_sequencer
//
// Builds and transmits the Modbus RTU response frame once the function
// handler completes a request. The handler results are latched on
// handler_done, the frame type is classified, header bytes are sent, READ
// payload words are fetched from the response DPRAM, the CRC-16 is appended
// and finally the inter-frame gap is enforced before seq_done pulses.
//
// Frame types:
//   EXC  : SADDR, func|0x80, code                      + CRC (5 bytes)
//   READ : SADDR, func, 2*qty, qty words (hi, lo)      + CRC (5+2*qty bytes)
//   ECHO : SADDR, 0x06, addr hi/lo, data hi/lo         + CRC (8 bytes)
//   other functions with no exception send nothing and complete at once.
//
// Ports:
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   handler_done       one-cycle start pulse; result inputs valid with it
//   func_code_r        request function code
//   addr_r, data_r     request address and data/quantity
//   exception_out      0 = normal response, else exception code
//   tx_quantity        payload word count for functions 03/04
//   bus                UART byte channel + DPRAM read port (master side)
//   busy               frame in progress (LATCH through GAP)
//   seq_done           one-cycle pulse when the frame is complete
//   seq_drop           one-cycle pulse: handler_done arrived while not idle
//   state_dbg          current FSM state, for observation only
// -----------------------------------------------------------------------------
module modbus_tx_sequencer #(
    parameter logic [7:0]  SADDR      = 8'h01,
    parameter logic [7:0]  MAX_QTY    = 8'd4,
    parameter logic [15:0] GAP_CYCLES = 16'd3500
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          handler_done,
    input  logic [7:0]                    func_code_r,
    input  logic [15:0]                   addr_r,
    input  logic [15:0]                   data_r,
    input  logic [7:0]                    exception_out,
    input  logic [7:0]                    tx_quantity,
    modbus_tx_sequencer_if.master         bus,
    output logic                          busy,
    output logic                          seq_done,
    output logic                          seq_drop,
    output logic [3:0]                    state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LATCH = 4'd1,
        S_HDR   = 4'd2,
        S_RD    = 4'd3,
        S_RDW   = 4'd4,
        S_DHI   = 4'd5,
        S_DLO   = 4'd6,
        S_CRCL  = 4'd7,
        S_CRCH  = 4'd8,
        S_GAP   = 4'd9,
        S_DONE  = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_EXC  = 2'd1,
        K_READ = 2'd2,
        K_ECHO = 2'd3
    } kind_t;

    // One byte of the reflected Modbus CRC-16 (poly 0xA001).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ 16'hA001;
            else      c = c >> 1;
        end
        return c;
    endfunction

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t      state_q,    state_d;
    kind_t       kind_q,     kind_d;
    logic [7:0]  func_q,     func_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] data_q,     data_d;
    logic [7:0]  exc_q,      exc_d;
    logic [7:0]  qty_q,      qty_d;
    logic [2:0]  hdr_idx_q,  hdr_idx_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [15:0] word_q,     word_d;
    logic [15:0] crc_q,      crc_d;
    logic [15:0] gap_cnt_q,  gap_cnt_d;
    logic        seq_drop_q, seq_drop_d;

    // Combinational helpers
    logic [7:0]  hdr_byte;
    logic [2:0]  hdr_last;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        dpram_ren_o;
    logic [7:0]  dpram_raddr_o;
    logic        hs;

    assign hs = tx_valid_o && bus.tx_ready;

    // ---------------------------------------------------------------------
    // Process 1: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            kind_q     <= K_NONE;
            func_q     <= 8'h00;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            exc_q      <= 8'h00;
            qty_q      <= 8'h00;
            hdr_idx_q  <= 3'd0;
            word_idx_q <= 8'h00;
            word_q     <= 16'h0000;
            crc_q      <= 16'hFFFF;
            gap_cnt_q  <= 16'h0000;
            seq_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            func_q     <= func_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            exc_q      <= exc_d;
            qty_q      <= qty_d;
            hdr_idx_q  <= hdr_idx_d;
            word_idx_q <= word_idx_d;
            word_q     <= word_d;
            crc_q      <= crc_d;
            gap_cnt_q  <= gap_cnt_d;
            seq_drop_q <= seq_drop_d;
        end
    end

    // ---------------------------------------------------------------------
    // Header byte selection: which byte the HDR state presents, and the
    // index of the last header byte for the current frame type.
    // ---------------------------------------------------------------------
    always_comb begin
        hdr_byte = 8'h00;
        hdr_last = 3'd2;
        case (kind_q)
            K_EXC: begin
                case (hdr_idx_q)
                    3'd0:    hdr_byte = SADDR;
                    3'd1:    hdr_byte = func_q | 8'h80;
                    default: hdr_byte = exc_q;
                endcase
            end
            K_READ: begin
                case (hdr_idx_q)
                    3'd0:    hdr_byte = SADDR;
                    3'd1:    hdr_byte = func_q;
                    // byte count = 2 * qty, truncated to 8 bits
                    default: hdr_byte = {qty_q[6:0], 1'b0};
                endcase
            end
            K_ECHO: begin
                hdr_last = 3'd5;
                case (hdr_idx_q)
                    3'd0:    hdr_byte = SADDR;
                    3'd1:    hdr_byte = func_q;
                    3'd2:    hdr_byte = addr_q[15:8];
                    3'd3:    hdr_byte = addr_q[7:0];
                    3'd4:    hdr_byte = data_q[15:8];
                    default: hdr_byte = data_q[7:0];
                endcase
            end
            default: begin
                hdr_byte = 8'h00;
                hdr_last = 3'd2;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        func_d     = func_q;
        addr_d     = addr_q;
        data_d     = data_q;
        exc_d      = exc_q;
        qty_d      = qty_q;
        hdr_idx_d  = hdr_idx_q;
        word_idx_d = word_idx_q;
        word_d     = word_q;
        crc_d      = crc_q;
        gap_cnt_d  = gap_cnt_q;
        // A start request outside IDLE is reported and otherwise ignored.
        seq_drop_d = handler_done && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (handler_done) begin
                    func_d  = func_code_r;
                    addr_d  = addr_r;
                    data_d  = data_r;
                    exc_d   = exception_out;
                    qty_d   = tx_quantity;
                    kind_d  = K_NONE;
                    crc_d   = 16'hFFFF;
                    state_d = S_LATCH;
                end
            end

            S_LATCH: begin
                hdr_idx_d  = 3'd0;
                word_idx_d = 8'h00;
                if (exc_q != 8'h00) begin
                    kind_d  = K_EXC;
                    state_d = S_HDR;
                end else if (func_q == 8'h03 || func_q == 8'h04) begin
                    // An out-of-range quantity turns into an illegal-value
                    // exception response rather than a read.
                    if (qty_q == 8'h00 || qty_q > MAX_QTY) begin
                        kind_d = K_EXC;
                        exc_d  = 8'h04;
                    end else begin
                        kind_d = K_READ;
                    end
                    state_d = S_HDR;
                end else if (func_q == 8'h06) begin
                    kind_d  = K_ECHO;
                    state_d = S_HDR;
                end else begin
                    kind_d  = K_NONE;
                    state_d = S_DONE;
                end
            end

            S_HDR: begin
                if (hs) begin
                    crc_d = crc16_byte(crc_q, tx_data_o);
                    if (hdr_idx_q == hdr_last) begin
                        word_idx_d = 8'h00;
                        state_d    = (kind_q == K_READ) ? S_RD : S_CRCL;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end

            S_RD: begin
                state_d = S_RDW;
            end

            S_RDW: begin
                word_d  = bus.dpram_rdata;
                state_d = S_DHI;
            end

            S_DHI: begin
                if (hs) begin
                    crc_d   = crc16_byte(crc_q, tx_data_o);
                    state_d = S_DLO;
                end
            end

            S_DLO: begin
                if (hs) begin
                    crc_d = crc16_byte(crc_q, tx_data_o);
                    if (word_idx_q == qty_q - 8'd1) begin
                        state_d = S_CRCL;
                    end else begin
                        word_idx_d = word_idx_q + 8'd1;
                        state_d    = S_RD;
                    end
                end
            end

            S_CRCL: begin
                if (hs) state_d = S_CRCH;
            end

            S_CRCH: begin
                if (hs) begin
                    gap_cnt_d = 16'h0000;
                    state_d   = S_GAP;
                end
            end

            S_GAP: begin
                // The gap must be contiguous idle time: any busy cycle on
                // the UART restarts the count.
                if (!bus.tx_idle) begin
                    gap_cnt_d = 16'h0000;
                end else if (gap_cnt_q == GAP_CYCLES - 16'd1) begin
                    state_d = S_DONE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Process 3: outputs (Moore, decoded from the state register so that
    // tx_valid falls as soon as reset clears state_q)
    // ---------------------------------------------------------------------
    always_comb begin
        tx_valid_o    = 1'b0;
        tx_data_o     = 8'h00;
        dpram_ren_o   = 1'b0;
        dpram_raddr_o = 8'h00;
        busy          = 1'b0;
        seq_done      = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_LATCH: busy = 1'b1;
            S_HDR: begin
                busy       = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = hdr_byte;
            end
            S_RD: begin
                busy          = 1'b1;
                dpram_ren_o   = 1'b1;
                dpram_raddr_o = word_idx_q;
            end
            S_RDW: busy = 1'b1;
            S_DHI: begin
                busy       = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = word_q[15:8];
            end
            S_DLO: begin
                busy       = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = word_q[7:0];
            end
            S_CRCL: begin
                busy       = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = crc_q[7:0];
            end
            S_CRCH: begin
                busy       = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = crc_q[15:8];
            end
            S_GAP:  busy     = 1'b1;
            S_DONE: seq_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.tx_valid    = tx_valid_o;
    assign bus.tx_data     = tx_data_o;
    assign bus.dpram_ren   = dpram_ren_o;
    assign bus.dpram_raddr = dpram_raddr_o;
    assign seq_drop        = seq_drop_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_modbus_tx_sequencer.sv
module tb_modbus_tx_sequencer;

    localparam logic [7:0]  SADDR   = 8'h01;
    localparam logic [7:0]  MAX_QTY = 8'd4;
    localparam logic [15:0] GAP     = 16'd16;

    // ---------------- clock / reset ----------------
    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        handler_done  = 1'b0;
    logic [7:0]  func_code_r   = 8'h00;
    logic [15:0] addr_r        = 16'h0000;
    logic [15:0] data_r        = 16'h0000;
    logic [7:0]  exception_out = 8'h00;
    logic [7:0]  tx_quantity   = 8'h00;
    logic        busy, seq_done, seq_drop;
    logic [3:0]  state_dbg;

    modbus_tx_sequencer_if sif ();

    modbus_tx_sequencer #(
        .SADDR      (SADDR),
        .MAX_QTY    (MAX_QTY),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .handler_done  (handler_done),
        .func_code_r   (func_code_r),
        .addr_r        (addr_r),
        .data_r        (data_r),
        .exception_out (exception_out),
        .tx_quantity   (tx_quantity),
        .bus           (sif),
        .busy          (busy),
        .seq_done      (seq_done),
        .seq_drop      (seq_drop),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_raddr_q[$];
    bit         exp_gap_q[$];
    logic [7:0] act_log[$];
    logic [15:0] mem [0:255];
    int done_cnt = 0, exp_done = 0;
    int drop_cnt = 0, exp_drop = 0;
    int total_bytes = 0, ren_cnt = 0;
    int idle_run = 0;
    bit hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit rand_ready = 1'b0, force_low = 1'b0;
    bit rand_idle = 1'b0, idle_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    // Reference model: the frame a request should produce, from the
    // response rules directly.
    task automatic model_req(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                             input logic [7:0] e, input logic [7:0] q);
        logic [7:0]  fr[$];
        logic [15:0] c;
        if (e != 8'h00) begin
            fr.push_back(SADDR); fr.push_back(f | 8'h80); fr.push_back(e);
        end else if (f == 8'h03 || f == 8'h04) begin
            if (q == 8'h00 || q > MAX_QTY) begin
                fr.push_back(SADDR); fr.push_back(f | 8'h80); fr.push_back(8'h04);
            end else begin
                fr.push_back(SADDR); fr.push_back(f); fr.push_back(8'(2 * q));
                for (int i = 0; i < int'(q); i++) begin
                    fr.push_back(mem[i][15:8]);
                    fr.push_back(mem[i][7:0]);
                    exp_raddr_q.push_back(8'(i));
                end
            end
        end else if (f == 8'h06) begin
            fr.push_back(SADDR); fr.push_back(f);
            fr.push_back(a[15:8]); fr.push_back(a[7:0]);
            fr.push_back(d[15:8]); fr.push_back(d[7:0]);
        end
        if (fr.size() != 0) begin
            c = 16'hFFFF;
            foreach (fr[i]) c = crc_ref(c, fr[i]);
            fr.push_back(c[7:0]);
            fr.push_back(c[15:8]);
        end
        foreach (fr[i]) exp_q.push_back(fr[i]);
        exp_gap_q.push_back(fr.size() != 0);
        exp_done++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_req(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                             input logic [7:0] e, input logic [7:0] q);
        @(posedge clk_in); #1;
        func_code_r = f; addr_r = a; data_r = d; exception_out = e; tx_quantity = q;
        handler_done = 1'b1;
        @(posedge clk_in); #1;
        handler_done = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                            input logic [7:0] e, input logic [7:0] q);
        model_req(f, a, d, e, q);
        pulse_req(f, a, d, e, q);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt != exp_done && n < budget) begin @(posedge clk_in); n++; end
        chk("frame_done_timeout", done_cnt, exp_done);
        repeat (2) @(posedge clk_in);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int n = 0;
        while (total_bytes < target && n < budget) begin @(posedge clk_in); n++; end
        chk("byte_wait_timeout", (total_bytes >= target), 1);
    endtask

    task automatic check_log(input string name, input logic [7:0] golden[$]);
        chk({name, "_len"}, act_log.size(), golden.size());
        for (int i = 0; i < golden.size() && i < act_log.size(); i++)
            chk(name, act_log[i], golden[i]);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_tx_valid"},  sif.tx_valid, 0);
        chk({tag, "_tx_data"},   sif.tx_data, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_seq_done"},  seq_done, 0);
        chk({tag, "_seq_drop"},  seq_drop, 0);
        chk({tag, "_dpram_ren"}, sif.dpram_ren, 0);
        chk({tag, "_raddr"},     sif.dpram_raddr, 0);
    endtask

    // ---------------- UART / DPRAM models ----------------
    initial begin
        sif.tx_ready = 1'b0;
        sif.tx_idle  = 1'b1;
        forever begin
            @(posedge clk_in); #1;
            sif.tx_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            sif.tx_idle  = idle_low ? 1'b0 : (rand_idle ? ($urandom_range(0, 9) != 0) : 1'b1);
        end
    end

    initial begin
        logic [7:0] ra;
        sif.dpram_rdata = 16'h0000;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && sif.dpram_ren) begin
                ra = sif.dpram_raddr;
                @(posedge clk_in); #1;
                sif.dpram_rdata = mem[ra];
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            hold_pending = 1'b0;
            idle_run     = 0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", sif.tx_valid, 1);
                chk("hold_data", sif.tx_data, hold_data);
            end
            hold_pending = sif.tx_valid && !sif.tx_ready;
            hold_data    = sif.tx_data;

            if (sif.tx_valid && sif.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte actual=%0h required=none", sif.tx_data);
                end else begin
                    chk("tx_byte", sif.tx_data, exp_q.pop_front());
                end
                total_bytes++;
                act_log.push_back(sif.tx_data);
            end

            if (sif.dpram_ren) begin
                ren_cnt++;
                if (exp_raddr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_dpram_read actual=%0h required=none", sif.dpram_raddr);
                end else begin
                    chk("dpram_raddr", sif.dpram_raddr, exp_raddr_q.pop_front());
                end
            end

            if (seq_drop) drop_cnt++;

            if (seq_done) begin
                done_cnt++;
                if (exp_gap_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_seq_done actual=1 required=0");
                end else if (exp_gap_q.pop_front()) begin
                    chk("gap_len", idle_run, GAP);
                end
            end

            if (sif.tx_valid && sif.tx_ready) idle_run = 0;
            else if (sif.tx_idle)             idle_run++;
            else                              idle_run = 0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] g[$];
        logic [15:0] c;
        int start, rens;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check_quiet("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);

        // Write single register echo with known CRC
        act_log.delete();
        send_req(8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
        wait_done(500);
        g = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        check_log("echo_golden", g);

        // Exception frame, no DPRAM traffic
        act_log.delete();
        rens = ren_cnt;
        send_req(8'h03, 16'h0000, 16'h0002, 8'h02, 8'h02);
        wait_done(500);
        g = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        check_log("exc_golden", g);
        chk("exc_no_dpram", ren_cnt - rens, 0);

        // Read 4 words, with a UART busy stretch after the last byte
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        act_log.delete();
        rens = ren_cnt;
        send_req(8'h04, 16'h0000, 16'h0004, 8'h00, 8'd4);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 500) begin @(posedge clk_in); n++; end
        end
        idle_low = 1'b1;
        repeat (4) @(posedge clk_in);
        idle_low = 1'b0;
        wait_done(500);
        g = '{8'h01, 8'h04, 8'h08, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        c = 16'hFFFF;
        foreach (g[i]) c = crc_ref(c, g[i]);
        g.push_back(c[7:0]);
        g.push_back(c[15:8]);
        check_log("read4_golden", g);
        chk("read4_dpram_reads", ren_cnt - rens, 4);

        // Quantity out of range (5) and zero both give exception 04
        act_log.delete();
        rens = ren_cnt;
        send_req(8'h04, 16'h0000, 16'h0005, 8'h00, 8'd5);
        wait_done(500);
        g = '{8'h01, 8'h84, 8'h04};
        c = 16'hFFFF;
        foreach (g[i]) c = crc_ref(c, g[i]);
        g.push_back(c[7:0]);
        g.push_back(c[15:8]);
        check_log("qty5_exc", g);
        act_log.delete();
        send_req(8'h04, 16'h0000, 16'h0000, 8'h00, 8'd0);
        wait_done(500);
        check_log("qty0_exc", g);
        chk("badqty_no_dpram", ren_cnt - rens, 0);

        // Unsupported function, no exception: completes with no bytes
        act_log.delete();
        send_req(8'h10, 16'h0000, 16'h0000, 8'h00, 8'h00);
        wait_done(100);
        chk("nofunc_len", act_log.size(), 0);

        // Stall mid-payload plus a dropped handler_done
        mem[0] = 16'hA5C3; mem[1] = 16'h0FF0; mem[2] = 16'h1234;
        start = total_bytes;
        send_req(8'h03, 16'h0010, 16'h0003, 8'h00, 8'd3);
        wait_bytes(start + 5, 500);
        force_low = 1'b1;
        pulse_req(8'h06, 16'hDEAD, 16'hBEEF, 8'h00, 8'h00);
        exp_drop++;
        repeat (4) @(posedge clk_in);
        force_low = 1'b0;
        wait_done(500);
        chk("stall_frame_len", total_bytes - start, 11);
        chk("drop_count", drop_cnt, exp_drop);

        // Reset after the third byte, then a fresh frame
        start = total_bytes;
        send_req(8'h06, 16'h1234, 16'h5678, 8'h00, 8'h00);
        wait_bytes(start + 3, 500);
        @(posedge clk_in); #2;
        rst_n_in = 1'b0;
        #1;
        check_quiet("midreset");
        exp_q.delete();
        exp_raddr_q.delete();
        exp_gap_q.delete();
        exp_done = done_cnt;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(posedge clk_in);
        act_log.delete();
        send_req(8'h06, 16'h0001, 16'h0003, 8'h00, 8'h00);
        wait_done(500);
        g = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        check_log("post_reset_echo", g);

        // Randomized requests with random UART back-pressure and idle
        rand_ready = 1'b1;
        rand_idle  = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic [7:0] f, e, q;
            int sel;
            for (int k = 0; k < 8; k++) mem[k] = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 4)      f = 8'h03;
            else if (sel < 7) f = 8'h04;
            else if (sel < 9) f = 8'h06;
            else              f = 8'($urandom_range(0, 255));
            q = 8'($urandom_range(0, 6));
            e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_req(f, 16'($urandom), 16'($urandom), e, q);
            wait_done(3000);
        end
        rand_ready = 1'b0;
        rand_idle  = 1'b0;
        repeat (4) @(posedge clk_in);

        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_raddr_q_empty", exp_raddr_q.size(), 0);
        chk("final_done_count", done_cnt, exp_done);
        chk("final_drop_count", drop_cnt, exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
